// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared widths and FSM encoding for the text overlay font path
package text_pkg;

    localparam int CHAR_W  = 7;
    localparam int LINE_W  = 4;
    localparam int ROM_AW  = CHAR_W + LINE_W;
    localparam int GLYPH_W = 8;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - one-hot pick of the first request at or after ptr, wrapping
module rr_prio_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] back;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        dbl  = {req, req} >> ptr;
        rot  = dbl[N-1:0];
        pick = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
        back = {pick, pick} << ptr;
        gnt  = back[2*N-1:N];
    end

endmodule

// File: rtl/text_font_arbiter.sv
// rtl/text_font_arbiter.sv - round-robin arbiter sharing one font ROM among text overlays
module text_font_arbiter
    import text_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ROM_LAT  = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [CHAR_W*N_REQ-1:0]  req_code,
    input  logic [LINE_W*N_REQ-1:0]  req_line,
    output logic [N_REQ-1:0]         gnt,
    output logic [ROM_AW-1:0]        rom_addr,
    output logic                     rom_en,
    input  logic [GLYPH_W-1:0]       rom_data,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [GLYPH_W-1:0]       rsp_data
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam int TW = (ROM_LAT + 1) * N_REQ;

    logic [0:0]        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     next_ptr;
    logic [PW-1:0]     sel_idx;
    logic [N_REQ-1:0]  owner;
    logic [CW-1:0]     cnt;
    logic [N_REQ-1:0]  pick_gnt;
    logic              accept;
    logic [ROM_AW-1:0] sel_addr;
    logic [TW-1:0]     tag_pipe;

    rr_prio_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    // While locked only the owner may be granted; a gap in its req yields no grant.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            gnt = (state == ST_LOCKED) ? (req & owner) : pick_gnt;
        end
    end

    assign accept = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = {CHAR_W'(req_code >> (CHAR_W * i)), LINE_W'(req_line >> (LINE_W * i))};
                sel_idx  = PW'(i);
            end
        end
        next_ptr = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ARB;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else if (state == ST_ARB) begin
            if (accept) begin
                ptr <= next_ptr;
                if (((gnt & req_lock) != '0) && (LOCK_MAX > 1)) begin
                    state <= ST_LOCKED;
                    owner <= gnt;
                    cnt   <= CW'(1);
                end
            end
        end else begin
            if (!accept) begin
                state <= ST_ARB;
            end else begin
                cnt <= cnt + 1'b1;
                if (((owner & req_lock) == '0) || (cnt == CW'(LOCK_MAX - 1))) begin
                    state <= ST_ARB;
                end
            end
        end
    end

    // The owner tag rides alongside the ROM read so the response is attributed correctly.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
            tag_pipe <= '0;
        end else begin
            rom_en   <= accept;
            tag_pipe <= {tag_pipe[TW-N_REQ-1:0], gnt};
            if (accept) begin
                rom_addr <= sel_addr;
            end
        end
    end

    assign rsp_valid = tag_pipe[TW-1 -: N_REQ];
    assign rsp_data  = (rsp_valid != '0) ? rom_data : '0;

endmodule

// File: tb/tb_text_font_arbiter.sv
// tb/tb_text_font_arbiter.sv - self-checking bench for text_font_arbiter
module tb_text_font_arbiter;

    localparam int N        = 3;
    localparam int ROM_LAT  = 3;
    localparam int LOCK_MAX = 8;

    logic          pclk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  req_lock;
    logic [7*N-1:0] req_code;
    logic [4*N-1:0] req_line;
    logic [N-1:0]  gnt;
    logic [10:0]   rom_addr;
    logic          rom_en;
    logic [7:0]    rom_data;
    logic [N-1:0]  rsp_valid;
    logic [7:0]    rsp_data;

    text_font_arbiter #(
        .N_REQ    (N),
        .ROM_LAT  (ROM_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_lock  (req_lock),
        .req_code  (req_code),
        .req_line  (req_line),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b0} ^ 8'h5A;
    endfunction

    logic [10:0] addr_q [ROM_LAT];
    initial for (int k = 0; k < ROM_LAT; k++) addr_q[k] = '0;
    always @(posedge pclk) begin
        addr_q[0] <= rom_addr;
        for (int k = 1; k < ROM_LAT; k++) addr_q[k] <= addr_q[k-1];
    end
    assign rom_data = rom_f(addr_q[ROM_LAT-1]);

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & 3'b001) != 3'b000;
    endfunction

    typedef struct {
        int          due;
        int          who;
        logic [10:0] addr;
    } rsp_t;

    rsp_t        pend[$];
    int          cyc = 0;
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_owner = 0;
    int          m_cnt = 0;
    bit          m_en = 0;
    logic [10:0] m_addr = '0;

    // Reference: grants from the round-robin/lock rules, responses scheduled 1+ROM_LAT after accept.
    always @(negedge pclk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic [7:0]   ed;
        int           gi;
        if (!rst_n) begin
            check("rst_gnt", int'(gnt), 0);
            check("rst_rom_en", int'(rom_en), 0);
            check("rst_rom_addr", int'(rom_addr), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
            check("rst_rsp_data", int'(rsp_data), 0);
            m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; m_en = 0; m_addr = '0;
            pend.delete();
        end else begin
            gi = -1;
            if (m_locked) begin
                if (bit_at(req, m_owner)) gi = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (gi < 0 && bit_at(req, (m_ptr + k) % N)) gi = (m_ptr + k) % N;
                end
            end
            eg = (gi >= 0) ? (3'b001 << gi) : 3'b000;
            ev = '0;
            ed = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev = 3'b001 << pend[0].who;
                ed = rom_f(pend[0].addr);
                void'(pend.pop_front());
            end
            check("gnt", int'(gnt), int'(eg));
            check("rom_en", int'(rom_en), int'(m_en));
            check("rom_addr", int'(rom_addr), int'(m_addr));
            check("rsp_valid", int'(rsp_valid), int'(ev));
            if (ev != '0) check("rsp_data", int'(rsp_data), int'(ed));
            if (gi >= 0) begin
                m_addr = {7'(req_code >> (7 * gi)), 4'(req_line >> (4 * gi))};
                m_en   = 1;
                pend.push_back('{due: cyc + 1 + ROM_LAT, who: gi, addr: m_addr});
                if (m_locked) begin
                    m_cnt++;
                    if (m_cnt == LOCK_MAX || !bit_at(req_lock, gi)) m_locked = 0;
                end else begin
                    m_ptr = (gi + 1) % N;
                    if (bit_at(req_lock, gi) && LOCK_MAX > 1) begin
                        m_locked = 1; m_owner = gi; m_cnt = 1;
                    end
                end
            end else begin
                m_en = 0;
                m_locked = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [N-1:0] gseq [12];
    logic [N-1:0] rseq [6];
    int           run;

    initial begin
        rst_n = 1'b0; req = '0; req_lock = '0; req_code = '0; req_line = '0;
        @(negedge pclk);
        check("reset_gnt", int'(gnt), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        tick(); tick();
        rst_n = 1'b1;

        // 'H' line 2 on requester 0
        req_code[6:0] = 7'h48; req_line[3:0] = 4'd2; req = 3'b001;
        @(negedge pclk); check("t1_gnt", int'(gnt), 'b001);
        tick(); req = '0;
        @(negedge pclk);
        check("t1_rom_en", int'(rom_en), 1);
        check("t1_rom_addr", int'(rom_addr), 'h482);
        repeat (ROM_LAT) @(negedge pclk);
        check("t1_rsp_valid", int'(rsp_valid), 'b001);
        check("t1_rsp_data", int'(rsp_data), 'h58);

        // requester 2 alone moves the pointer back to 0, then all three contend
        tick(); req_code[20:14] = 7'h30; req_line[11:8] = 4'd7; req = 3'b100;
        tick();
        req_code = {7'h7F, 7'h00, 7'h41}; req_line = {4'd15, 4'd15, 4'd0}; req = 3'b111;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (i < 6) gseq[i] = gnt;
            if (i >= 4) rseq[i-4] = rsp_valid;
            tick();
            if (i == 5) req = '0;
        end
        for (int i = 0; i < 6; i++) begin
            check("t2_gnt_rot", int'(gseq[i]), 1 << (i % 3));
            check("t2_rsp_rot", int'(rseq[i]), 1 << (i % 3));
        end

        // requester 0 locked with requester 1 waiting
        req = 3'b011; req_lock = 3'b001;
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk); gseq[i] = gnt;
            tick();
        end
        req = '0; req_lock = '0;
        run = 0;
        while (run < 12 && gseq[run] == 3'b001) run++;
        check("t3_lock_run", run, 8);
        check("t3_after_lock", int'(gseq[8]), 'b010);
        check("t3_relock", int'(gseq[9]), 'b001);
        check("t3_relock_hold", int'(gseq[10]), 'b001);

        // owner gap while requester 2 waits
        tick(); req = 3'b001; req_lock = 3'b001;
        @(negedge pclk); check("t4_acc", int'(gnt), 'b001);
        tick();
        @(negedge pclk); check("t4_locked", int'(gnt), 'b001);
        tick(); req = 3'b100;
        @(negedge pclk); check("t4_gap", int'(gnt), 'b000);
        tick(); req = 3'b101;
        @(negedge pclk); check("t4_released", int'(gnt), 'b100);
        tick(); req = '0; req_lock = '0;

        // reset with two lookups in flight
        req = 3'b011;
        @(negedge pclk); check("t5_gnt0", int'(gnt), 'b001);
        tick(); req = 3'b010;
        @(negedge pclk); check("t5_gnt1", int'(gnt), 'b010);
        tick(); req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_now_rom_en", int'(rom_en), 0);
        check("t5_now_rom_addr", int'(rom_addr), 0);
        check("t5_now_gnt", int'(gnt), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk); check("t5_no_stale_rsp", int'(rsp_valid), 0);
        end

        // idle after a grant to 1, then 0 and 2 request together
        tick(); req = 3'b010;
        @(negedge pclk); check("t6_gnt1", int'(gnt), 'b010);
        tick(); req = '0;
        repeat (10) @(negedge pclk);
        check("t6_idle_gnt", int'(gnt), 0);
        check("t6_idle_rom_en", int'(rom_en), 0);
        tick(); req = 3'b101;
        @(negedge pclk); check("t6_ptr2", int'(gnt), 'b100);
        tick(); req = 3'b001;
        @(negedge pclk); check("t6_then0", int'(gnt), 'b001);
        tick(); req = '0;
        repeat (8) @(negedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
